// File: rtl/seq_divider_6bit_pkg.sv
// Shared definitions for the restoring divider: FSM encodings and default operand width.
package seq_divider_6bit_pkg;

    // Default operand width, shared with the mantissa multiplier path.
    localparam int unsigned DEFAULT_WIDTH = 6;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_divider_6bit_pkg

// File: rtl/seq_divider_6bit_if.sv
// Start/busy/done handshake plus operand and result bus of the divider.
interface seq_divider_6bit_if
    import seq_divider_6bit_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    // Requester side.
    modport master (
        output start, a, b,
        input  quotient, remainder, busy, done, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, a, b,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface : seq_divider_6bit_if

// File: rtl/seq_divider_6bit_div_step.sv
// One restoring-division step: trial subtract, keep or restore, emit the quotient bit.
module div_step
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next_c,
    output logic             q_bit_c
);

    // Extra top bit carries the borrow, i.e. the sign of the WIDTH+1-bit trial.
    logic [WIDTH+1:0] diff;

    // Trial subtraction and restore select.
    always_comb begin
        diff       = {1'b0, rem_in, dvd_msb} - {2'b00, divisor};
        q_bit_c    = ~diff[WIDTH+1];
        rem_next_c = q_bit_c ? diff[WIDTH-1:0] : {rem_in[WIDTH-2:0], dvd_msb};
    end

endmodule : div_step

// File: rtl/seq_divider_6bit.sv
// Multi-cycle restoring unsigned divider, one quotient bit per clock.
// Optional feature macro: DIV_ZERO_FASTPATH_EN (b==0 skips CALC and finishes next cycle).
module seq_divider_6bit
    import seq_divider_6bit_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_divider_6bit_if.slave  bus
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] rem_next_c;
    logic             q_bit_c;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in     (rem_q),
        .dvd_msb    (dvd_q[WIDTH-1]),
        .divisor    (dsr_q),
        .rem_next_c (rem_next_c),
        .q_bit_c    (q_bit_c)
    );

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    // Next-state and next-register values; results only change on entry to DONE.
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = CALC;
                    dvd_d   = bus.a;
                    dsr_d   = bus.b;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    busy_d  = 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
                    if (bus.b == '0) begin
                        state_d     = DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = bus.a;
                        dbz_d       = 1'b1;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d = rem_next_c;
                quo_d = {quo_q[WIDTH-2:0], q_bit_c};
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = {quo_q[WIDTH-2:0], q_bit_c};
                    remainder_d = rem_next_c;
                    dbz_d       = (dsr_q == '0);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : seq_divider_6bit

// File: tb/tb_seq_divider_6bit.sv
// Directed self-checking bench for seq_divider_6bit (WIDTH=6).
module tb_seq_divider_6bit;

    localparam int unsigned W = 6;
`ifdef DIV_ZERO_FASTPATH_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = W + 1;
`endif

    logic clk;
    logic rst_n;
    int   chk_cnt;
    int   pass_cnt;

    seq_divider_6bit_if #(.WIDTH(W)) bus ();

    seq_divider_6bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: launch a/b at a negedge, drop start after the accepting edge,
    // return the number of edges (accepting edge = 1) until done is seen; 0 on timeout.
    task automatic do_div(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
        chk_cnt++; if (bus.quotient !== 6'd0) $display("FAIL reset_quotient got %0d want 0", bus.quotient); else pass_cnt++;
        chk_cnt++; if (bus.remainder !== 6'd0) $display("FAIL reset_remainder got %0d want 0", bus.remainder); else pass_cnt++;
        chk_cnt++; if (bus.div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        do_div(6'd12, 6'd18, lat);
        chk_cnt++; if (lat != 7) $display("FAIL lat_12_18 got %0d want 7", lat); else pass_cnt++;
        chk_cnt++; if (bus.quotient !== 6'd0) $display("FAIL q_12_18 got %0d want 0", bus.quotient); else pass_cnt++;
        chk_cnt++; if (bus.remainder !== 6'd12) $display("FAIL r_12_18 got %0d want 12", bus.remainder); else pass_cnt++;
        chk_cnt++; if (bus.div_by_zero !== 1'b0) $display("FAIL dbz_12_18 got %b want 0", bus.div_by_zero); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (bus.done !== 1'b0) $display("FAIL done_width_12_18 got %b want 0", bus.done); else pass_cnt++;

        do_div(6'd63, 6'd5, lat);
        chk_cnt++; if (lat != 7) $display("FAIL lat_63_5 got %0d want 7", lat); else pass_cnt++;
        chk_cnt++; if (bus.quotient !== 6'd12) $display("FAIL q_63_5 got %0d want 12", bus.quotient); else pass_cnt++;
        chk_cnt++; if (bus.remainder !== 6'd3) $display("FAIL r_63_5 got %0d want 3", bus.remainder); else pass_cnt++;

        do_div(6'd63, 6'd1, lat);
        chk_cnt++; if (bus.quotient !== 6'd63) $display("FAIL q_63_1 got %0d want 63", bus.quotient); else pass_cnt++;
        chk_cnt++; if (bus.remainder !== 6'd0) $display("FAIL r_63_1 got %0d want 0", bus.remainder); else pass_cnt++;
    endtask

    task automatic test_div_zero();
        int lat;
        do_div(6'd40, 6'd0, lat);
        chk_cnt++; if (lat != ZERO_LAT) $display("FAIL lat_40_0 got %0d want %0d", lat, ZERO_LAT); else pass_cnt++;
        chk_cnt++; if (bus.quotient !== 6'd63) $display("FAIL q_40_0 got %0d want 63", bus.quotient); else pass_cnt++;
        chk_cnt++; if (bus.remainder !== 6'd40) $display("FAIL r_40_0 got %0d want 40", bus.remainder); else pass_cnt++;
        chk_cnt++; if (bus.div_by_zero !== 1'b1) $display("FAIL dbz_40_0 got %b want 1", bus.div_by_zero); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (bus.done !== 1'b0) $display("FAIL done_width_40_0 got %b want 0", bus.done); else pass_cnt++;
        // Next non-zero divide must clear the flag.
        do_div(6'd7, 6'd2, lat);
        chk_cnt++; if (bus.div_by_zero !== 1'b0) $display("FAIL dbz_clear got %b want 0", bus.div_by_zero); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        int lat2;
        lat = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 6'd50;
        bus.b     = 6'd7;
        @(posedge clk); #1;
        // Keep start high with new operands while busy.
        bus.a = 6'd9;
        bus.b = 6'd3;
        chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL busy_after_accept got %b want 1", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.quotient !== 6'd3) $display("FAIL q_held_in_calc got %0d want 3", bus.quotient); else pass_cnt++;
        for (int i = 2; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk_cnt++; if (lat != 7) $display("FAIL lat_50_7 got %0d want 7", lat); else pass_cnt++;
        chk_cnt++; if (bus.quotient !== 6'd7) $display("FAIL q_50_7 got %0d want 7", bus.quotient); else pass_cnt++;
        chk_cnt++; if (bus.remainder !== 6'd1) $display("FAIL r_50_7 got %0d want 1", bus.remainder); else pass_cnt++;
        // start still high in the DONE cycle launches 9/3.
        lat2 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (i == 1) begin
                chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept_busy got %b want 1", bus.busy); else pass_cnt++;
            end
            if (bus.done) begin
                lat2 = i;
                break;
            end
        end
        chk_cnt++; if (lat2 != 7) $display("FAIL lat_9_3 got %0d want 7", lat2); else pass_cnt++;
        chk_cnt++; if (bus.quotient !== 6'd3) $display("FAIL q_9_3 got %0d want 3", bus.quotient); else pass_cnt++;
        chk_cnt++; if (bus.remainder !== 6'd0) $display("FAIL r_9_3 got %0d want 0", bus.remainder); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit saw_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 6'd33;
        bus.b     = 6'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.done !== 1'b0) $display("FAIL abort_done got %b want 0", bus.done); else pass_cnt++;
        chk_cnt++; if (bus.quotient !== 6'd0) $display("FAIL abort_quotient got %0d want 0", bus.quotient); else pass_cnt++;
        chk_cnt++; if (bus.remainder !== 6'd0) $display("FAIL abort_remainder got %0d want 0", bus.remainder); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk_cnt++; if (saw_done !== 1'b0) $display("FAIL abort_no_done got %b want 0", saw_done); else pass_cnt++;
        do_div(6'd33, 6'd4, lat);
        chk_cnt++; if (lat != 7) $display("FAIL lat_33_4 got %0d want 7", lat); else pass_cnt++;
        chk_cnt++; if (bus.quotient !== 6'd8) $display("FAIL q_33_4 got %0d want 8", bus.quotient); else pass_cnt++;
        chk_cnt++; if (bus.remainder !== 6'd1) $display("FAIL r_33_4 got %0d want 1", bus.remainder); else pass_cnt++;
    endtask

    task automatic test_sweep();
        int lat;
        int exp_q;
        int exp_r;
        for (int av = 0; av < 64; av++) begin
            for (int bv = 1; bv < 64; bv++) begin
                do_div(W'(av), W'(bv), lat);
                exp_q = av / bv;
                exp_r = av % bv;
                chk_cnt++;
                if (lat != 7 || bus.quotient !== W'(exp_q) || bus.remainder !== W'(exp_r)) begin
                    $display("FAIL sweep %0d/%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=7",
                             av, bv, bus.quotient, bus.remainder, lat, exp_q, exp_r);
                end else begin
                    pass_cnt++;
                end
                @(posedge clk); #1;
                chk_cnt++;
                if (bus.done !== 1'b0) $display("FAIL sweep_done_width %0d/%0d got %b want 0", av, bv, bus.done);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_seq_divider_6bit
